// File: rtl/io_bus_arbiter.sv
// Two-port arbiter/sequencer for the shared IO bus: grants one master, runs one bus cycle, acks.
// Define IO_ARB_ROUND_ROBIN_EN for alternating priority; otherwise port 0 has fixed priority.
module io_bus_arbiter #(
    parameter int                        DATA_BIT_WIDTH = 32,
    parameter logic [DATA_BIT_WIDTH-1:0] RESET_VALUE    = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req0,
    input  logic                      we0,
    input  logic [DATA_BIT_WIDTH-1:0] addr0,
    input  logic [DATA_BIT_WIDTH-1:0] wdata0,
    output logic                      ack0,
    output logic [DATA_BIT_WIDTH-1:0] rdata0,
    input  logic                      req1,
    input  logic                      we1,
    input  logic [DATA_BIT_WIDTH-1:0] addr1,
    input  logic [DATA_BIT_WIDTH-1:0] wdata1,
    output logic                      ack1,
    output logic [DATA_BIT_WIDTH-1:0] rdata1,
    output logic [DATA_BIT_WIDTH-1:0] bus_addr,
    output logic                      bus_wrtEn,
    output logic [DATA_BIT_WIDTH-1:0] bus_wdata,
    output logic                      bus_wdrive,
    input  logic [DATA_BIT_WIDTH-1:0] bus_rdata,
    output logic                      busy,
    output logic                      owner,
    output logic [1:0]                state_dbg
);

    // Handshake: a master raises reqN with we/addr/wdata stable and holds it until it sees
    // ackN (one-cycle pulse); it drops reqN at the following edge. Request lines are only
    // sampled in IDLE, so anything they do during XFER/DONE has no effect.
    typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DONE = 2'd2} state_t;

    state_t                    state;
    logic                      lat_we;
    logic [DATA_BIT_WIDTH-1:0] lat_addr;
    logic [DATA_BIT_WIDTH-1:0] lat_wdata;
    logic                      grant;

`ifdef IO_ARB_ROUND_ROBIN_EN
    logic last_owner;
    // On contention the port that did not win last time gets the bus.
    assign grant = (req0 && req1) ? ~last_owner : req1;
`else
    assign grant = ~req0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            owner     <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata0    <= RESET_VALUE;
            rdata1    <= RESET_VALUE;
`ifdef IO_ARB_ROUND_ROBIN_EN
            last_owner <= 1'b1;
`endif
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner     <= grant;
                        lat_we    <= grant ? we1 : we0;
                        lat_addr  <= grant ? addr1 : addr0;
                        lat_wdata <= grant ? wdata1 : wdata0;
`ifdef IO_ARB_ROUND_ROBIN_EN
                        last_owner <= grant;
`endif
                        state     <= XFER;
                    end
                end
                XFER: begin
                    if (!lat_we) begin
                        if (owner) rdata1 <= bus_rdata;
                        else       rdata0 <= bus_rdata;
                    end
                    if (owner) ack1 <= 1'b1;
                    else       ack0 <= 1'b1;
                    state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Bus is driven only in XFER; address 0 elsewhere selects no device.
    assign bus_addr   = (state == XFER) ? lat_addr : '0;
    assign bus_wrtEn  = (state == XFER) && lat_we;
    assign bus_wdrive = (state == XFER) && lat_we;
    assign bus_wdata  = ((state == XFER) && lat_we) ? lat_wdata : '0;
    assign busy       = (state != IDLE);
    assign state_dbg  = state;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter: reset, write, read, contention, latching, mid-transfer reset.
module tb_io_bus_arbiter;

    localparam int          W  = 32;
    localparam logic [W-1:0] RV = 32'hA5A5_0001;
`ifdef IO_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         req0, we0, req1, we1;
    logic [W-1:0] addr0, wdata0, addr1, wdata1;
    logic         ack0, ack1;
    logic [W-1:0] rdata0, rdata1;
    logic [W-1:0] bus_addr, bus_wdata, bus_rdata;
    logic         bus_wrtEn, bus_wdrive, busy, owner;
    logic [1:0]   state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    // clock / reset
    always #5 clk = ~clk;

    io_bus_arbiter #(.DATA_BIT_WIDTH(W), .RESET_VALUE(RV)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .bus_addr(bus_addr), .bus_wrtEn(bus_wrtEn), .bus_wdata(bus_wdata),
        .bus_wdrive(bus_wdrive), .bus_rdata(bus_rdata),
        .busy(busy), .owner(owner), .state_dbg(state_dbg)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        bus_rdata = '0;
        tick(); tick();
        n_checks++; if ({ack0, ack1, busy, owner} !== 4'b0000) $display("FAIL reset_ctl: got %b expected 0000", {ack0, ack1, busy, owner}); else n_pass++;
        n_checks++; if ({bus_wrtEn, bus_wdrive} !== 2'b00 || bus_addr !== '0 || bus_wdata !== '0) $display("FAIL reset_bus: addr %h wdata %h expected 0", bus_addr, bus_wdata); else n_pass++;
        n_checks++; if (rdata0 !== RV || rdata1 !== RV) $display("FAIL reset_rdata: got %h %h expected %h", rdata0, rdata1, RV); else n_pass++;
        n_checks++; if (state_dbg !== 2'd0) $display("FAIL reset_state: got %0d expected 0", state_dbg); else n_pass++;
        reset = 1'b1;
        tick();
        n_checks++; if (busy !== 1'b0) $display("FAIL idle_no_req: busy %b expected 0", busy); else n_pass++;
    endtask

    task automatic test_write_p0();
        req0 = 1; we0 = 1; addr0 = 32'hF000_0000; wdata0 = 32'h0000_1234;
        bus_rdata = 32'hDEAD_DEAD;
        tick();
        n_checks++; if (busy !== 1 || owner !== 0 || state_dbg !== 2'd1) $display("FAIL wr_xfer_ctl: busy %b owner %b state %0d expected 1 0 1", busy, owner, state_dbg); else n_pass++;
        n_checks++; if (bus_addr !== 32'hF000_0000) $display("FAIL wr_addr: got %h expected f0000000", bus_addr); else n_pass++;
        n_checks++; if (bus_wrtEn !== 1 || bus_wdrive !== 1) $display("FAIL wr_en: got %b%b expected 11", bus_wrtEn, bus_wdrive); else n_pass++;
        n_checks++; if (bus_wdata !== 32'h0000_1234) $display("FAIL wr_data: got %h expected 00001234", bus_wdata); else n_pass++;
        n_checks++; if (ack0 !== 0) $display("FAIL wr_early_ack: got %b expected 0", ack0); else n_pass++;
        tick();
        n_checks++; if (ack0 !== 1 || ack1 !== 0) $display("FAIL wr_ack: got %b%b expected 10", ack0, ack1); else n_pass++;
        n_checks++; if (bus_addr !== '0 || bus_wrtEn !== 0 || bus_wdrive !== 0 || bus_wdata !== '0) $display("FAIL wr_done_bus: addr %h expected 0", bus_addr); else n_pass++;
        n_checks++; if (rdata0 !== RV) $display("FAIL wr_rdata0: got %h expected %h", rdata0, RV); else n_pass++;
        req0 = 0;
        tick();
        n_checks++; if (ack0 !== 0 || busy !== 0) $display("FAIL wr_after: ack0 %b busy %b expected 0 0", ack0, busy); else n_pass++;
    endtask

    task automatic test_read_p1();
        req1 = 1; we1 = 0; addr1 = 32'hF000_0000; wdata1 = 32'h7777_7777;
        tick();
        n_checks++; if (owner !== 1 || bus_addr !== 32'hF000_0000) $display("FAIL rd_xfer: owner %b addr %h expected 1 f0000000", owner, bus_addr); else n_pass++;
        n_checks++; if (bus_wrtEn !== 0 || bus_wdrive !== 0 || bus_wdata !== '0) $display("FAIL rd_en: got %b%b data %h expected 00 0", bus_wrtEn, bus_wdrive, bus_wdata); else n_pass++;
        bus_rdata = 32'h0000_BEEF;
        tick();
        n_checks++; if (ack1 !== 1 || ack0 !== 0) $display("FAIL rd_ack: got %b%b expected 01", ack0, ack1); else n_pass++;
        n_checks++; if (rdata1 !== 32'h0000_BEEF) $display("FAIL rd_data: got %h expected 0000beef", rdata1); else n_pass++;
        n_checks++; if (rdata0 !== RV) $display("FAIL rd_rdata0: got %h expected %h", rdata0, RV); else n_pass++;
        req1 = 0; bus_rdata = 32'h1111_2222;
        tick();
        n_checks++; if (ack1 !== 0 || rdata1 !== 32'h0000_BEEF) $display("FAIL rd_hold: ack1 %b rdata1 %h expected 0 0000beef", ack1, rdata1); else n_pass++;
    endtask

    task automatic test_contention();
        int ph, k;
        logic exp_o;
        reset = 0;
        req0 = 1; we0 = 0; addr0 = 32'h0000_0010;
        req1 = 1; we1 = 0; addr1 = 32'h0000_0020;
        bus_rdata = 32'hC0DE_0000;
        tick();
        reset = 1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            ph = (i - 1) % 3;
            k  = (i - 1) / 3;
            exp_o = RR ? k[0] : 1'b0;
            if (ph == 0) begin
                n_checks++; if (busy !== 1 || owner !== exp_o) $display("FAIL cont_grant%0d: busy %b owner %b expected 1 %b", k, busy, owner, exp_o); else n_pass++;
                n_checks++; if (bus_addr !== (exp_o ? 32'h20 : 32'h10)) $display("FAIL cont_addr%0d: got %h expected %h", k, bus_addr, exp_o ? 32'h20 : 32'h10); else n_pass++;
            end else if (ph == 1) begin
                n_checks++; if (ack0 !== !exp_o || ack1 !== exp_o) $display("FAIL cont_ack%0d: got %b%b expected %b%b", k, ack0, ack1, !exp_o, exp_o); else n_pass++;
            end else begin
                n_checks++; if (ack0 !== 0 || ack1 !== 0 || busy !== 0) $display("FAIL cont_idle%0d: ack %b%b busy %b expected 000", k, ack0, ack1, busy); else n_pass++;
            end
        end
        n_checks++; if (rdata0 !== 32'hC0DE_0000) $display("FAIL cont_rdata0: got %h expected c0de0000", rdata0); else n_pass++;
        n_checks++; if (rdata1 !== (RR ? 32'hC0DE_0000 : RV)) $display("FAIL cont_rdata1: got %h expected %h", rdata1, RR ? 32'hC0DE_0000 : RV); else n_pass++;
        req0 = 0; req1 = 0;
        tick();
    endtask

    task automatic test_latch();
        req0 = 1; we0 = 1; addr0 = 32'h0000_0040; wdata0 = 32'h0000_00AA;
        tick();
        addr0 = 32'h0000_0080; wdata0 = 32'h0000_00BB; we0 = 0;
        #1;
        n_checks++; if (bus_addr !== 32'h0000_0040 || bus_wdata !== 32'h0000_00AA || bus_wrtEn !== 1) $display("FAIL latch_bus: addr %h data %h expected 00000040 000000aa", bus_addr, bus_wdata); else n_pass++;
        tick();
        n_checks++; if (ack0 !== 1) $display("FAIL latch_ack: got %b expected 1", ack0); else n_pass++;
        req0 = 0;
        tick();
    endtask

    task automatic test_reset_mid_xfer();
        req0 = 1; we0 = 1; addr0 = 32'h0000_0300; wdata0 = 32'h0000_0033;
        tick();
        n_checks++; if (busy !== 1) $display("FAIL mid_pre: busy %b expected 1", busy); else n_pass++;
        reset = 0;
        req0 = 0; req1 = 1; we1 = 1; addr1 = 32'h0000_0100; wdata1 = 32'h0000_0055;
        #1;
        n_checks++; if (bus_addr !== '0 || bus_wrtEn !== 0 || bus_wdrive !== 0 || bus_wdata !== '0) $display("FAIL mid_bus: addr %h expected 0", bus_addr); else n_pass++;
        n_checks++; if ({busy, owner, ack0, ack1} !== 4'b0000) $display("FAIL mid_ctl: got %b expected 0000", {busy, owner, ack0, ack1}); else n_pass++;
        n_checks++; if (rdata0 !== RV || rdata1 !== RV) $display("FAIL mid_rdata: got %h %h expected %h", rdata0, rdata1, RV); else n_pass++;
        tick();
        n_checks++; if (ack0 !== 0 || busy !== 0) $display("FAIL mid_no_ack: ack0 %b busy %b expected 0 0", ack0, busy); else n_pass++;
        reset = 1;
        tick();
        n_checks++; if (busy !== 1 || owner !== 1 || bus_addr !== 32'h0000_0100 || bus_wdata !== 32'h0000_0055) $display("FAIL post_xfer: owner %b addr %h data %h expected 1 00000100 00000055", owner, bus_addr, bus_wdata); else n_pass++;
        tick();
        n_checks++; if (ack1 !== 1 || ack0 !== 0) $display("FAIL post_ack: got %b%b expected 01", ack0, ack1); else n_pass++;
        req1 = 0;
        tick();
        n_checks++; if (busy !== 0 || ack1 !== 0) $display("FAIL post_idle: busy %b ack1 %b expected 0 0", busy, ack1); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write_p0();
        test_read_p1();
        test_contention();
        test_latch();
        test_reset_mid_xfer();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
